// File: rtl/pump_alternator_if.sv
// rtl/pump_alternator_if.sv - sensor, feedback and pump-drive signal bundle for pump_alternator
// master drives sensors/feedback/clear; slave is the alternator that drives the pump outputs.
interface pump_alternator_if;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       s4;
    logic       fb_a;
    logic       fb_b;
    logic       clr_fault;
    logic       pa;
    logic       pb;
    logic       lead;
    logic       fault;
    logic [1:0] pump_fail;

    modport master (
        output s1, s2, s3, s4, fb_a, fb_b, clr_fault,
        input  pa, pb, lead, fault, pump_fail
    );

    modport slave (
        input  s1, s2, s3, s4, fb_a, fb_b, clr_fault,
        output pa, pb, lead, fault, pump_fail
    );
endinterface

// File: rtl/pump_alternator.sv
// rtl/pump_alternator.sv - duty/standby alternator for two transfer pumps with failover and fault latch
// Optional macro PUMP_ASSIST_EN: second pump assists after a sustained low upper tank.
module pump_alternator #(
    parameter int MIN_ON       = 8,
    parameter int MIN_OFF      = 4,
    parameter int FB_TIMEOUT   = 3,
`ifdef PUMP_ASSIST_EN
    parameter int ASSIST_DELAY = 16,
`endif
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    pump_alternator_if.slave pif
);

    typedef enum logic [1:0] {ST_OFF, ST_START, ST_RUN, ST_FAULT} state_t;

    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] FB_C      = CNT_W'(FB_TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
    logic [CNT_W-1:0] fb_cnt_q, fb_cnt_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic             sel_q, sel_d;
    logic             lead_q, lead_d;
    logic             pa_q, pa_d;
    logic             pb_q, pb_d;
    logic             fault_q, fault_d;
    logic [1:0]       pump_fail_q, pump_fail_d;
    logic             assist_d;
`ifdef PUMP_ASSIST_EN
    localparam logic [CNT_W-1:0] ASSIST_C = CNT_W'(ASSIST_DELAY);
    logic [CNT_W-1:0] assist_cnt_q, assist_cnt_d;
    logic             assist_q;
`endif

    logic             start, bad, fb_sel, sel_off, normal_stop, run_d;
    logic [1:0]       avail, avail_d;
    logic [CNT_W-1:0] off_inc, fb_inc, on_inc;

    assign start   = pif.s1 & ~pif.s3;
    assign bad     = (pif.s2 & ~pif.s1) | (pif.s4 & ~pif.s3);
    assign avail   = ~pump_fail_q;
    assign fb_sel  = sel_q ? pif.fb_b : pif.fb_a;
    assign sel_off = avail[lead_q] ? lead_q : ~lead_q;
    assign off_inc = sat_inc(off_cnt_q);
    assign fb_inc  = sat_inc(fb_cnt_q);
    assign on_inc  = sat_inc(on_cnt_q);

    // Timers compare the count including the current cycle, so MIN_OFF idle cycles allow a start.
    always_comb begin
        state_d     = state_q;
        off_cnt_d   = off_cnt_q;
        fb_cnt_d    = fb_cnt_q;
        on_cnt_d    = on_cnt_q;
        sel_d       = sel_q;
        fault_d     = fault_q;
        pump_fail_d = pump_fail_q;
        normal_stop = 1'b0;

        if (pif.clr_fault && state_q != ST_FAULT) begin
            pump_fail_d = 2'b00;
        end

        if (bad) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    off_cnt_d = off_inc;
                    if (start && off_inc >= MIN_OFF_C && |avail) begin
                        state_d  = ST_START;
                        sel_d    = sel_off;
                        fb_cnt_d = '0;
                    end
                end
                ST_START: begin
                    fb_cnt_d = fb_inc;
                    if (!pif.s1) begin
                        state_d   = ST_OFF;
                        off_cnt_d = '0;
                    end else if (fb_sel) begin
                        state_d  = ST_RUN;
                        on_cnt_d = '0;
                    end else if (fb_inc >= FB_C) begin
                        pump_fail_d[sel_q] = 1'b1;
                        if (avail[~sel_q]) begin
                            sel_d    = ~sel_q;
                            fb_cnt_d = '0;
                        end else begin
                            state_d   = ST_OFF;
                            off_cnt_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    on_cnt_d = on_inc;
                    if (!pif.s1) begin
                        state_d   = ST_OFF;
                        off_cnt_d = '0;
                    end else if (!fb_sel) begin
                        pump_fail_d[sel_q] = 1'b1;
                        state_d            = ST_OFF;
                        off_cnt_d          = '0;
                    end else if (pif.s4 && on_inc >= MIN_ON_C) begin
                        state_d     = ST_OFF;
                        off_cnt_d   = '0;
                        normal_stop = 1'b1;
                    end
                end
                default: begin
                    if (pif.clr_fault) begin
                        state_d     = ST_OFF;
                        off_cnt_d   = '0;
                        fault_d     = 1'b0;
                        pump_fail_d = 2'b00;
                    end
                end
            endcase
        end

        // Lead follows the surviving pump; it only alternates while both are healthy.
        avail_d = ~pump_fail_d;
        case (avail_d)
            2'b11:   lead_d = normal_stop ? ~lead_q : lead_q;
            2'b01:   lead_d = 1'b0;
            2'b10:   lead_d = 1'b1;
            default: lead_d = lead_q;
        endcase

        assist_d = 1'b0;
`ifdef PUMP_ASSIST_EN
        assist_cnt_d = '0;
        if (state_q == ST_RUN && state_d == ST_RUN && !pif.s3) begin
            assist_cnt_d = sat_inc(assist_cnt_q);
            assist_d     = (assist_q || assist_cnt_d >= ASSIST_C) && avail_d[~sel_q];
        end
`endif

        run_d = (state_d == ST_START) || (state_d == ST_RUN);
        pa_d  = run_d && (sel_d == 1'b0 || assist_d);
        pb_d  = run_d && (sel_d == 1'b1 || assist_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            off_cnt_q    <= MIN_OFF_C;
            fb_cnt_q     <= '0;
            on_cnt_q     <= '0;
            sel_q        <= 1'b0;
            lead_q       <= 1'b0;
            pa_q         <= 1'b0;
            pb_q         <= 1'b0;
            fault_q      <= 1'b0;
            pump_fail_q  <= 2'b00;
`ifdef PUMP_ASSIST_EN
            assist_cnt_q <= '0;
            assist_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            off_cnt_q    <= off_cnt_d;
            fb_cnt_q     <= fb_cnt_d;
            on_cnt_q     <= on_cnt_d;
            sel_q        <= sel_d;
            lead_q       <= lead_d;
            pa_q         <= pa_d;
            pb_q         <= pb_d;
            fault_q      <= fault_d;
            pump_fail_q  <= pump_fail_d;
`ifdef PUMP_ASSIST_EN
            assist_cnt_q <= assist_cnt_d;
            assist_q     <= assist_d;
`endif
        end
    end

    assign pif.pa        = pa_q;
    assign pif.pb        = pb_q;
    assign pif.lead      = lead_q;
    assign pif.fault     = fault_q;
    assign pif.pump_fail = pump_fail_q;

endmodule

// File: tb/tb_pump_alternator.sv
// tb/tb_pump_alternator.sv - scoreboard testbench for pump_alternator
// Stimulus bits {s1,s2,s3,s4,fb_a,fb_b,clr_fault}; expected bits {pa,pb,lead,fault,pump_fail[1:0]}.
module tb_pump_alternator;

`ifdef PUMP_ASSIST_EN
    localparam bit ASSIST = 1'b1;
`else
    localparam bit ASSIST = 1'b0;
`endif

    typedef struct packed {
        logic [6:0] stim;
        logic [5:0] want;
    } step_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    step_t      steps[$];
    logic [5:0] sb_q[$];

    pump_alternator_if pif ();

    pump_alternator dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] s);
        {pif.s1, pif.s2, pif.s3, pif.s4, pif.fb_a, pif.fb_b, pif.clr_fault} = s;
    endtask

    function automatic logic [5:0] outs();
        return {pif.pa, pif.pb, pif.lead, pif.fault, pif.pump_fail};
    endfunction

    task automatic add(input logic [6:0] s, input logic [5:0] w, input int n);
        repeat (n) steps.push_back({s, w});
    endtask

    task automatic do_reset();
        drive(7'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        steps.delete();
    endtask

    task automatic test_reset();
        logic [5:0] got, want;
        drive(7'b0);
        rst = 1'b1;
        sb_q.push_back(6'b000000);
        @(negedge clk);
        got = outs(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_held got=%b want=%b", got, want);
        end
        rst = 1'b0;
        sb_q.push_back(6'b000000);
        @(posedge clk); @(negedge clk);
        got = outs(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_idle got=%b want=%b", got, want);
        end
    endtask

    task automatic test_normal_stop();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 1);   // start on A
        add(7'b1000100, 6'b100000, 4);   // feedback -> RUN, on_cnt 0..3
        add(7'b1011100, 6'b100000, 4);   // s4 early: held to MIN_ON
        add(7'b1011100, 6'b001000, 1);   // stop, lead toggles to B
        add(7'b1000000, 6'b001000, 3);   // MIN_OFF holding
        add(7'b1000000, 6'b011000, 1);   // B starts 4 cycles after stop
        add(7'b1000010, 6'b011000, 1);   // RUN on B
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL normal_stop step %0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_dry_run();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 1);
        add(7'b1000100, 6'b100000, 3);   // RUN, on_cnt reaches 2
        add(7'b0000100, 6'b000000, 1);   // dry: stop now, no toggle
        add(7'b1000000, 6'b000000, 3);
        add(7'b1000000, 6'b100000, 1);
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL dry_run step %0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_fb_fail();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 3);   // A gets FB_TIMEOUT cycles
        add(7'b1000000, 6'b011001, 1);   // A failed, swap to B
        add(7'b1000010, 6'b011001, 1);   // RUN on B
        add(7'b1000000, 6'b001011, 1);   // B feedback lost
        add(7'b1000000, 6'b001011, 6);   // nothing available
        add(7'b1000001, 6'b001000, 1);   // clear
        add(7'b1000000, 6'b011000, 1);   // starts resume on lead B
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL fb_fail step %0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_fault();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 1);
        add(7'b1000100, 6'b100000, 1);
        add(7'b0100100, 6'b000100, 1);   // s2 without s1
        add(7'b0100001, 6'b000100, 1);   // clear ignored while bad
        add(7'b0100000, 6'b000100, 1);
        add(7'b1000000, 6'b000100, 1);   // sensors ok, still latched
        add(7'b1000001, 6'b000000, 1);
        add(7'b1000000, 6'b000000, 3);
        add(7'b1000000, 6'b100000, 1);
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL fault step %0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 3);
        add(7'b1000000, 6'b011001, 1);
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL async_pre step %0d got=%b want=%b", i, got, want);
            end
        end
        rst = 1'b1;
        sb_q.push_back(6'b000000);
        #1;
        got = outs(); want = sb_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_reset got=%b want=%b", got, want);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_assist();
        logic [5:0] got, want;
        do_reset();
        add(7'b1000000, 6'b100000, 1);
        add(7'b1000100, 6'b100000, 1);
        add(7'b1000100, 6'b100000, 15);
        add(7'b1000100, ASSIST ? 6'b110000 : 6'b100000, 1);
        add(7'b1010100, 6'b100000, 1);   // s3 returns: assist off
        foreach (steps[i]) begin
            drive(steps[i].stim);
            sb_q.push_back(steps[i].want);
            @(posedge clk); @(negedge clk);
            got = outs(); want = sb_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL assist step %0d got=%b want=%b", i, got, want);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(7'b0);
        test_reset();
        test_normal_stop();
        test_dry_run();
        test_fb_fail();
        test_fault();
        test_async_reset();
        test_assist();
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
